// File: rtl/boot_load_ctrl.sv
// Boot loader: parses host length/word stream into imem and dmem,
// acknowledges each phase, then releases the core and forwards bytes.
module boot_load_ctrl #(
   parameter int unsigned IADDR_W  = 12,
   parameter int unsigned DADDR_W  = 16,
   parameter int unsigned DBASE    = 0,
   parameter logic [7:0]  ACK_PROG = 8'h99,
   parameter logic [7:0]  ACK_DATA = 8'hAA
) (
   input  logic               sys_clock,
   input  logic               reset,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic               rx_err,
   output logic               imem_we,
   output logic [IADDR_W-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               dmem_valid,
   input  logic               dmem_ready,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [31:0]        dmem_wdata,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic               core_rst_n,
   output logic               fwd_valid,
   output logic [7:0]         fwd_data,
   output logic               err
);

   typedef enum logic [3:0] {
      S_PLEN, S_PROG, S_ACKP, S_DLEN, S_DATA,
      S_DFLUSH, S_ACKD, S_RUN, S_ERR
   } state_e;

   localparam logic [32:0] IMAX = 33'd1 << (IADDR_W + 2);
   localparam logic [32:0] DMAX = 33'd1 << (DADDR_W + 2);

   state_e             state_q, state_d;
   logic [31:0]        len_q, len_d;
   logic [31:0]        bcnt_q, bcnt_d;
   logic [31:0]        word_q, word_d;
   logic               iwe_q, iwe_d;
   logic [IADDR_W-1:0] iaddr_q, iaddr_d;
   logic [31:0]        iwdata_q, iwdata_d;
   logic               dval_q, dval_d;
   logic [DADDR_W-1:0] daddr_q, daddr_d;
   logic [31:0]        dwdata_q, dwdata_d;
   logic               fval_q, fval_d;
   logic [7:0]         fdata_q, fdata_d;

   logic [1:0]  lane;
   logic [31:0] word_nx, len_nx, len_fin, bcnt_inc;
   logic        wdone, last, len_done, dhs, load_st;

   always_comb begin
      lane     = bcnt_q[1:0];
      word_nx  = word_q;
      word_nx[{lane, 3'b000} +: 8] = rx_data;
      len_nx   = len_q;
      len_nx[{lane, 3'b000} +: 8] = rx_data;
      bcnt_inc = bcnt_q + 32'd1;
      last     = bcnt_inc == len_q;
      wdone    = (lane == 2'd3) || last;
      // Length bytes may already be complete when ACKP hands over to DLEN
      len_fin  = bcnt_q[2] ? len_q : len_nx;
      len_done = (rx_valid && bcnt_q == 32'd3) || bcnt_q == 32'd4;
      dhs      = dval_q & dmem_ready;
      load_st  = state_q != S_RUN && state_q != S_ERR;
   end

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_PLEN;
         len_q    <= '0;
         bcnt_q   <= '0;
         word_q   <= '0;
         iwe_q    <= 1'b0;
         iaddr_q  <= '0;
         iwdata_q <= '0;
         dval_q   <= 1'b0;
         daddr_q  <= DADDR_W'(DBASE);
         dwdata_q <= '0;
         fval_q   <= 1'b0;
         fdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         bcnt_q   <= bcnt_d;
         word_q   <= word_d;
         iwe_q    <= iwe_d;
         iaddr_q  <= iaddr_d;
         iwdata_q <= iwdata_d;
         dval_q   <= dval_d;
         daddr_q  <= daddr_d;
         dwdata_q <= dwdata_d;
         fval_q   <= fval_d;
         fdata_q  <= fdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      bcnt_d   = bcnt_q;
      word_d   = word_q;
      iwe_d    = 1'b0;
      iaddr_d  = iwe_q ? iaddr_q + IADDR_W'(1) : iaddr_q;
      iwdata_d = iwdata_q;
      dval_d   = dval_q & ~dmem_ready;
      daddr_d  = dhs ? daddr_q + DADDR_W'(1) : daddr_q;
      dwdata_d = dwdata_q;
      fval_d   = 1'b0;
      fdata_d  = fdata_q;
      unique case (state_q)
         S_PLEN, S_DLEN: begin
            if (rx_valid && !bcnt_q[2]) begin
               len_d  = len_nx;
               bcnt_d = bcnt_inc;
            end
            if (len_done) begin
               len_d  = len_fin;
               bcnt_d = '0;
               word_d = '0;
               if (state_q == S_PLEN) begin
                  if ({1'b0, len_fin} > IMAX) state_d = S_ERR;
                  else if (len_fin == '0)     state_d = S_ACKP;
                  else                        state_d = S_PROG;
               end else begin
                  if ({1'b0, len_fin} > DMAX) state_d = S_ERR;
                  else if (len_fin == '0)     state_d = S_ACKD;
                  else                        state_d = S_DATA;
               end
            end
         end
         S_PROG: begin
            if (rx_valid) begin
               word_d = word_nx;
               bcnt_d = bcnt_inc;
               if (wdone) begin
                  iwe_d    = 1'b1;
                  iwdata_d = word_nx;
                  word_d   = '0;
               end
               if (last) begin
                  state_d = S_ACKP;
                  bcnt_d  = '0;
               end
            end
         end
         S_ACKP: begin
            if (rx_valid && !bcnt_q[2]) begin
               len_d  = len_nx;
               bcnt_d = bcnt_inc;
            end
            if (tx_ready) state_d = S_DLEN;
         end
         S_DATA: begin
            if (rx_valid) begin
               word_d = word_nx;
               bcnt_d = bcnt_inc;
               if (wdone) begin
                  word_d = '0;
                  if (dval_q && !dmem_ready) begin
                     state_d = S_ERR;
                  end else begin
                     dval_d   = 1'b1;
                     dwdata_d = word_nx;
                     if (last) state_d = S_DFLUSH;
                  end
               end
            end
         end
         S_DFLUSH: if (dhs) state_d = S_ACKD;
         S_ACKD:   if (tx_ready) state_d = S_RUN;
         S_RUN: begin
            fval_d = rx_valid;
            if (rx_valid) fdata_d = rx_data;
         end
         S_ERR: ;
         default: state_d = S_ERR;
      endcase
      if (load_st && rx_err) state_d = S_ERR;
      if (state_d == S_ERR) begin
         iwe_d  = 1'b0;
         dval_d = 1'b0;
      end
   end

   always_comb begin
      imem_we    = iwe_q;
      imem_addr  = iaddr_q;
      imem_wdata = iwdata_q;
      dmem_valid = dval_q;
      dmem_addr  = daddr_q;
      dmem_wdata = dwdata_q;
      fwd_valid  = fval_q;
      fwd_data   = fdata_q;
      tx_valid   = 1'b0;
      tx_data    = '0;
      core_rst_n = 1'b0;
      err        = 1'b0;
      unique case (state_q)
         S_ACKP: begin
            tx_valid = 1'b1;
            tx_data  = ACK_PROG;
         end
         S_ACKD: begin
            tx_valid = 1'b1;
            tx_data  = ACK_DATA;
         end
         S_RUN:   core_rst_n = 1'b1;
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: load phases, backpressure,
// error/reset recovery and post-boot forwarding.
module tb_boot_load_ctrl;

   localparam int IW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_err = 1'b0;
   logic          imem_we;
   logic [IW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          dmem_valid;
   logic          dmem_ready = 1'b1;
   logic [DW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready = 1'b1;
   logic          core_rst_n;
   logic          fwd_valid;
   logic [7:0]    fwd_data;
   logic          err;

   boot_load_ctrl dut (
      .sys_clock (clk),
      .reset     (rst_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_err    (rx_err),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .dmem_valid(dmem_valid),
      .dmem_ready(dmem_ready),
      .dmem_addr (dmem_addr),
      .dmem_wdata(dmem_wdata),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .core_rst_n(core_rst_n),
      .fwd_valid (fwd_valid),
      .fwd_data  (fwd_data),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [IW-1:0] i_a[$];
   logic [31:0]   i_d[$];
   logic [DW-1:0] d_a[$];
   logic [31:0]   d_d[$];
   int            d_t[$];
   logic [7:0]    t_b[$];
   int            t_t[$];

   always @(negedge clk) begin
      cyc++;
      if (imem_we) begin
         i_a.push_back(imem_addr);
         i_d.push_back(imem_wdata);
      end
      if (dmem_valid && dmem_ready) begin
         d_a.push_back(dmem_addr);
         d_d.push_back(dmem_wdata);
         d_t.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
         t_b.push_back(tx_data);
         t_t.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clr_q();
      i_a.delete(); i_d.delete();
      d_a.delete(); d_d.delete(); d_t.delete();
      t_b.delete(); t_t.delete();
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send32(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_err = 1'b0;
      dmem_ready = 1'b1;
      repeat (3) @(posedge clk);
      clr_q();
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_run(input string nm);
      int n = 0;
      while (!core_rst_n && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(core_rst_n), 32'd1);
   endtask

   function automatic logic [7:0] db(input int i);
      return 8'(i * 13 + 1);
   endfunction

   function automatic logic [31:0] dword(input int k);
      return {db(4*k+3), db(4*k+2), db(4*k+1), db(4*k)};
   endfunction

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       e;
      logic       fv;
      logic [7:0] fd;
   } rv_t;

   rv_t        rtab[6];
   logic [7:0] prog[168];
   logic [31:0] w0;
   logic       stable;

   initial begin
      rtab[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A};
      rtab[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
      rtab[2] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF};
      rtab[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
      rtab[4] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3};
      rtab[5] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h00};
      for (int i = 0; i < 168; i++) prog[i] = 8'(i * 7 + 3);
      prog[0] = 8'h15; prog[1] = 8'h00; prog[2] = 8'h40; prog[3] = 8'h00;
      prog[4] = 8'h84; prog[5] = 8'h0a; prog[6] = 8'h40; prog[7] = 8'h08;

      // reset state and basic load
      do_reset();
      @(negedge clk);
      chk("rst_flags", 32'({core_rst_n, err, imem_we, dmem_valid,
                           tx_valid, fwd_valid}), 32'd0);
      chk("rst_iaddr", 32'(imem_addr), 32'd0);
      chk("rst_txdata", 32'(tx_data), 32'd0);
      send32(32'd0);
      send32(32'd4);
      send32(32'h00400015);
      wait_run("basic_boot");
      repeat (2) @(negedge clk);
      chk("basic_txcnt", t_b.size(), 32'd2);
      chk("basic_dcnt", d_a.size(), 32'd1);
      chk("basic_icnt", i_a.size(), 32'd0);
      if (t_b.size() == 2 && d_a.size() == 1) begin
         chk("basic_tx0", 32'(t_b[0]), 32'h99);
         chk("basic_tx1", 32'(t_b[1]), 32'hAA);
         chk("basic_daddr", 32'(d_a[0]), 32'd0);
         chk("basic_ddata", d_d[0], 32'h00400015);
         chk("basic_order", 32'((t_t[0] < d_t[0]) && (d_t[0] < t_t[1])),
             32'd1);
      end

      // post-boot forwarding table
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         rx_valid = rtab[i].v;
         rx_data  = rtab[i].d;
         rx_err   = rtab[i].e;
         @(negedge clk);
         chk($sformatf("run%0d_fv", i), 32'(fwd_valid), 32'(rtab[i].fv));
         if (rtab[i].fv)
            chk($sformatf("run%0d_fd", i), 32'(fwd_data), 32'(rtab[i].fd));
         chk($sformatf("run%0d_stat", i),
             32'({tx_valid, err, core_rst_n}), 32'b001);
      end
      rx_valid = 1'b0;
      rx_err   = 1'b0;

      // program load, 168 bytes
      do_reset();
      send32(32'd168);
      for (int i = 0; i < 168; i++) send(prog[i]);
      send32(32'd0);
      wait_run("prog_boot");
      repeat (2) @(negedge clk);
      chk("prog_icnt", i_a.size(), 32'd42);
      chk("prog_dcnt", d_a.size(), 32'd0);
      chk("prog_txcnt", t_b.size(), 32'd2);
      if (i_a.size() == 42) begin
         chk("prog_w0", i_d[0], 32'h00400015);
         chk("prog_w1", i_d[1], 32'h08400A84);
         chk("prog_last", 32'(i_a[41]), 32'd41);
         for (int w = 0; w < 42; w++) begin
            chk($sformatf("prog_a%0d", w), 32'(i_a[w]), 32'(w));
            chk($sformatf("prog_d%0d", w), i_d[w],
                {prog[4*w+3], prog[4*w+2], prog[4*w+1], prog[4*w]});
         end
      end

      // partial final word
      do_reset();
      send32(32'd6);
      for (int i = 1; i <= 6; i++) send(8'(i));
      send32(32'd0);
      wait_run("part_boot");
      repeat (2) @(negedge clk);
      chk("part_icnt", i_a.size(), 32'd2);
      if (i_a.size() == 2) begin
         chk("part_a0", 32'(i_a[0]), 32'd0);
         chk("part_d0", i_d[0], 32'h04030201);
         chk("part_a1", 32'(i_a[1]), 32'd1);
         chk("part_d1", i_d[1], 32'h00000605);
      end

      // data backpressure, then overrun
      do_reset();
      send32(32'd0);
      send32(32'd1300);
      dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(db(i));
      w0 = dword(0);
      @(negedge clk);
      chk("bp_valid", 32'(dmem_valid), 32'd1);
      for (int i = 4; i < 7; i++) send(db(i));
      stable = 1'b1;
      for (int c = 0; c < 94; c++) begin
         @(negedge clk);
         if (!(dmem_valid && dmem_addr == '0 && dmem_wdata == w0 && !err))
            stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      chk("bp_noerr", 32'(err), 32'd0);
      @(posedge clk); #1;
      dmem_ready = 1'b1;
      for (int i = 7; i < 40; i++) send(db(i));
      repeat (3) @(negedge clk);
      chk("bp_dcnt", d_a.size(), 32'd10);
      if (d_a.size() == 10) begin
         for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_a%0d", k), 32'(d_a[k]), 32'(k));
            chk($sformatf("bp_d%0d", k), d_d[k], dword(k));
         end
      end
      dmem_ready = 1'b0;
      for (int i = 40; i < 48; i++) send(db(i));
      repeat (2) @(negedge clk);
      chk("ovr_err", 32'({err, core_rst_n, dmem_valid}), 32'b100);
      for (int i = 48; i < 52; i++) send(db(i));
      dmem_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("ovr_dcnt", d_a.size(), 32'd10);
      chk("ovr_stay", 32'({err, core_rst_n}), 32'b10);

      // rx_err during program phase, same-cycle byte dropped
      do_reset();
      send32(32'd8);
      send(8'h11);
      send(8'h22);
      @(posedge clk); #1;
      rx_err = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
      @(posedge clk); #1;
      rx_err = 1'b0; rx_valid = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(i + 4));
      repeat (2) @(negedge clk);
      chk("rxerr_flags", 32'({err, core_rst_n}), 32'b10);
      chk("rxerr_icnt", i_a.size(), 32'd0);
      chk("rxerr_txcnt", t_b.size(), 32'd0);

      // program length one past the limit
      do_reset();
      send32(32'd16385);
      send32(32'h12345678);
      repeat (2) @(negedge clk);
      chk("plen_big_err", 32'(err), 32'd1);
      chk("plen_big_icnt", i_a.size(), 32'd0);

      // program length exactly at the limit
      do_reset();
      send32(32'd16384);
      repeat (2) @(negedge clk);
      chk("plen_max_noerr", 32'(err), 32'd0);
      send32(32'hDEADBEEF);
      repeat (2) @(negedge clk);
      chk("plen_max_icnt", i_a.size(), 32'd1);
      if (i_a.size() == 1) chk("plen_max_d", i_d[0], 32'hDEADBEEF);

      // reset mid-data, then clean reload
      do_reset();
      send32(32'd4);
      send32(32'h11223344);
      send32(32'd8);
      for (int i = 0; i < 5; i++) send(db(i));
      repeat (2) @(negedge clk);
      chk("mid_dcnt", d_a.size(), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      chk("mid_async", 32'({core_rst_n, err, dmem_valid, imem_we, tx_valid}),
          32'd0);
      chk("mid_iaddr", 32'(imem_addr), 32'd0);
      repeat (2) @(posedge clk);
      clr_q();
      #1 rst_n = 1'b1;
      send32(32'd4);
      send32(32'hCAFEF00D);
      send32(32'd4);
      send32(32'h0BADBEEF);
      wait_run("reload_boot");
      repeat (2) @(negedge clk);
      chk("reload_icnt", i_a.size(), 32'd1);
      chk("reload_dcnt", d_a.size(), 32'd1);
      chk("reload_txcnt", t_b.size(), 32'd2);
      if (i_a.size() == 1 && d_a.size() == 1) begin
         chk("reload_ia", 32'(i_a[0]), 32'd0);
         chk("reload_id", i_d[0], 32'hCAFEF00D);
         chk("reload_da", 32'(d_a[0]), 32'd0);
         chk("reload_dd", d_d[0], 32'h0BADBEEF);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
